// File: rtl/spi_imu_responder.sv
// spi_imu_responder
//   SPI Mode 0 slave that emulates the MPU-6050 register map, so the FPGA can
//   stand in for the IMU. SCLK, MOSI and CS_n are oversampled in the clk
//   domain. Command bytes are decoded here. Burst reads are served from a
//   sample snapshot. Writes are strobed out, and PWR_MGMT_1 is stored locally.
//
// Ports
//   clk           system clock, at least 8x the SCLK frequency
//   rst           synchronous active-high reset
//   spi_sclk      SPI clock from the master (CPOL=0)
//   spi_mosi      master-out data
//   spi_cs_n      chip select, active low
//   spi_miso      slave-out data
//   sample_valid  one-cycle strobe that latches sample_data into the shadow
//   sample_data   {accel_x, accel_y, gyro_x, gyro_y}, 16-bit signed each
//   xfer_active   high while a transaction is being decoded
//   wr_strobe     one-cycle pulse per accepted register write
//   wr_addr       address of the accepted write
//   wr_data       data of the accepted write
//   pwr_mgmt      current PWR_MGMT_1 value
module spi_imu_responder #(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0]  PWR_RST_VAL  = 8'h40,
  parameter int unsigned SYNC_STAGES  = 2      // minimum 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  input  logic        sample_valid,
  input  logic [63:0] sample_data,
  output logic        xfer_active,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  pwr_mgmt
);

  localparam logic [6:0] ADDR_PWR_MGMT = 7'h6B;
  localparam logic [6:0] ADDR_WHO_AM_I = 7'h75;

  typedef enum logic [1:0] {
    ST_WAIT_CS_HIGH = 2'd0,
    ST_IDLE         = 2'd1,
    ST_CMD          = 2'd2,
    ST_DATA         = 2'd3
  } state_e;

  // Read map. Addresses not listed here read 0x00.
  function automatic logic [7:0] reg_read(input logic [6:0]  addr,
                                          input logic [63:0] snap,
                                          input logic [7:0]  pwr);
    logic [7:0] val;
    case (addr)
      7'h3B:         val = snap[63:56];  // accel_x hi
      7'h3C:         val = snap[55:48];  // accel_x lo
      7'h3D:         val = snap[47:40];  // accel_y hi
      7'h3E:         val = snap[39:32];  // accel_y lo
      7'h43:         val = snap[31:24];  // gyro_x hi
      7'h44:         val = snap[23:16];  // gyro_x lo
      7'h45:         val = snap[15:8];   // gyro_y hi
      7'h46:         val = snap[7:0];    // gyro_y lo
      ADDR_PWR_MGMT: val = pwr;
      ADDR_WHO_AM_I: val = WHO_AM_I_VAL;
      default:       val = 8'h00;
    endcase
    return val;
  endfunction

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_n_prev_q;

  // Transaction state
  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;   // first seven bits of the byte being received
  logic [6:0]  tx_shift_q;   // bits still to be shifted out after the MSB
  logic [6:0]  addr_q;
  logic        rw_q;         // 1 = read
  logic [63:0] shadow_q;
  logic [63:0] snapshot_q;

  // Registered outputs
  logic        miso_q;
  logic        xfer_active_q;
  logic        wr_strobe_q;
  logic [6:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [7:0]  pwr_mgmt_q;

  logic        sclk_s;
  logic        mosi_s;
  logic        cs_n_s;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        cs_rise;
  logic        cs_fall;
  logic [7:0]  rx_byte;
  logic [6:0]  addr_inc;
  logic [7:0]  cmd_rd_byte;
  logic [7:0]  next_rd_byte;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;

  // Complete byte, including the bit arriving on this rising edge
  assign rx_byte      = {rx_shift_q, mosi_s};
  assign addr_inc     = addr_q + 7'd1;
  assign cmd_rd_byte  = reg_read(rx_byte[6:0], snapshot_q, pwr_mgmt_q);
  assign next_rd_byte = reg_read(addr_inc, snapshot_q, pwr_mgmt_q);

  // Synchronize the SPI pins and keep one cycle of history for edge detection.
  // cs_n is cleared to 0 in reset. That forces WAIT_CS_HIGH to see a real high
  // on the pin before any falling edge can be recognised.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_n_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  // Shadow register always tracks the newest sample, even mid-transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 64'd0;
    end else if (sample_valid) begin
      shadow_q <= sample_data;
    end else begin
      shadow_q <= shadow_q;
    end
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_CS_HIGH;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 7'd0;
      addr_q        <= 7'd0;
      rw_q          <= 1'b0;
      snapshot_q    <= 64'd0;
      miso_q        <= 1'b0;
      xfer_active_q <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= 7'd0;
      wr_data_q     <= 8'd0;
      pwr_mgmt_q    <= PWR_RST_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      if (cs_rise) begin
        // End of transaction: any partial byte is discarded
        state_q       <= ST_IDLE;
        bit_cnt_q     <= 3'd0;
        miso_q        <= 1'b0;
        xfer_active_q <= 1'b0;
      end else begin
        case (state_q)
          ST_WAIT_CS_HIGH: begin
            if (cs_n_s) begin
              state_q <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (cs_fall) begin
              // A same-cycle sample wins over the shadow
              snapshot_q    <= sample_valid ? sample_data : shadow_q;
              bit_cnt_q     <= 3'd0;
              tx_shift_q    <= 7'd0;
              miso_q        <= 1'b0;
              xfer_active_q <= 1'b1;
              state_q       <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_shift_q <= rx_byte[6:0];
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rw_q    <= rx_byte[7];
                addr_q  <= rx_byte[6:0];
                state_q <= ST_DATA;
                if (rx_byte[7]) begin
                  miso_q     <= cmd_rd_byte[7];
                  tx_shift_q <= cmd_rd_byte[6:0];
                end
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              rx_shift_q <= rx_byte[6:0];
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                addr_q <= addr_inc;
                if (rw_q) begin
                  miso_q     <= next_rd_byte[7];
                  tx_shift_q <= next_rd_byte[6:0];
                end else begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= addr_q;
                  wr_data_q   <= rx_byte;
                  if (addr_q == ADDR_PWR_MGMT) begin
                    pwr_mgmt_q <= rx_byte;
                  end
                end
              end
            end else if (sclk_fall) begin
              // The MSB was placed at the byte boundary, so the falling edge
              // right after the boundary (bit_cnt 0) must not shift.
              if (rw_q && (bit_cnt_q != 3'd0)) begin
                miso_q     <= tx_shift_q[6];
                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
              end
            end
          end
          default: begin
            state_q <= ST_WAIT_CS_HIGH;
          end
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign xfer_active = xfer_active_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign pwr_mgmt    = pwr_mgmt_q;

endmodule

// File: tb/tb_spi_imu_responder.sv
module tb_spi_imu_responder;

  localparam int HALF = 5;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_miso;
  logic        sample_valid;
  logic [63:0] sample_data;
  logic        xfer_active;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  pwr_mgmt;

  spi_imu_responder #(
    .WHO_AM_I_VAL(8'h68),
    .PWR_RST_VAL (8'h40),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .xfer_active (xfer_active),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwr_mgmt    (pwr_mgmt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitors: record every cycle of wr_strobe, count MISO highs while watched
  logic [14:0] wr_q[$];
  int          miso_hi_cnt = 0;
  logic        quiet_watch = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) wr_q.push_back({wr_addr, wr_data});
    if (quiet_watch && spi_miso) miso_hi_cnt <= miso_hi_cnt + 1;
  end

  // Reference model state
  logic [63:0] model_shadow = 64'd0;
  logic [63:0] model_snap   = 64'd0;
  logic [7:0]  model_pwr    = 8'h40;

  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] exp_rx;
    int         exp_wr;
    logic [7:0] exp_pwr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register contents the master should see, built from the sample bytes
  function automatic logic [7:0] model_read(input logic [6:0] a);
    logic [7:0] b [8];
    int idx;
    for (int k = 0; k < 8; k++) b[k] = model_snap[63-8*k -: 8];
    if (a == 7'h6B) return model_pwr;
    if (a == 7'h75) return 8'h68;
    idx = int'(a) - 59;  // 0x3B
    if (idx >= 0 && idx <= 3) return b[idx];
    if (idx >= 8 && idx <= 11) return b[idx-4];
    return 8'h00;
  endfunction

  task automatic pulse_sample(input logic [63:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    model_shadow = d;
  endtask

  // Mode 0 master: MOSI set while SCLK low, MISO sampled just before rising edge
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = b[i];
      wait_clk(HALF);
      r[i] = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_xfer(input int n, input int pulse_after, input logic [63:0] pulse_data);
    logic [7:0] r;
    model_snap = model_shadow;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    check("xfer_active_hi", 64'(xfer_active), 64'd1);
    for (int i = 0; i < n; i++) begin
      spi_bits(tx_buf[i], 8, r);
      rx_buf[i] = r;
      if (i == pulse_after) pulse_sample(pulse_data);
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(6);
    check("xfer_active_lo", 64'(xfer_active), 64'd0);
  endtask

  initial begin
    logic [7:0]  r;
    logic [7:0]  exp_b [12];
    logic [7:0]  exp_c [12];
    logic [6:0]  picks [5];
    logic [6:0]  a;
    logic [6:0]  cur;
    logic [14:0] got;
    logic        rw;
    int          base;
    int          n;
    int          pa;

    rst          = 1'b1;
    spi_sclk     = 1'b0;
    spi_mosi     = 1'b0;
    spi_cs_n     = 1'b1;
    sample_valid = 1'b0;
    sample_data  = 64'd0;

    vecs[0] = '{8'hF5, 8'h00, 8'h68, 0, 8'h40};  // WHO_AM_I
    vecs[1] = '{8'hEB, 8'h00, 8'h40, 0, 8'h40};  // PWR_MGMT_1 reset value
    vecs[2] = '{8'hBB, 8'h00, 8'h12, 0, 8'h40};  // accel_x hi
    vecs[3] = '{8'hC6, 8'h00, 8'hFE, 0, 8'h40};  // gyro_y lo
    vecs[4] = '{8'hBF, 8'h00, 8'h00, 0, 8'h40};  // accel_z reads zero
    vecs[5] = '{8'h6B, 8'h01, 8'h00, 1, 8'h01};  // write PWR_MGMT_1
    vecs[6] = '{8'hEB, 8'h00, 8'h01, 0, 8'h01};  // read it back
    vecs[7] = '{8'h10, 8'h55, 8'h00, 1, 8'h01};  // write elsewhere: strobe only
    vecs[8] = '{8'h90, 8'h00, 8'h00, 0, 8'h01};  // no internal effect
    vecs[9] = '{8'hC3, 8'h00, 8'h80, 0, 8'h01};  // gyro_x hi

    exp_b = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h80, 8'h01, 8'h7F, 8'hFE};
    exp_c = '{8'hCA, 8'hFE, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h03, 8'h04, 8'h05, 8'h06};
    picks = '{7'h6A, 7'h6B, 7'h74, 7'h75, 7'h7F};

    // Reset values
    wait_clk(4);
    check("rst_miso",     64'(spi_miso),    64'd0);
    check("rst_xfer",     64'(xfer_active), 64'd0);
    check("rst_wr_strobe",64'(wr_strobe),   64'd0);
    check("rst_wr_addr",  64'(wr_addr),     64'd0);
    check("rst_wr_data",  64'(wr_data),     64'd0);
    check("rst_pwr",      64'(pwr_mgmt),    64'h40);
    rst = 1'b0;
    wait_clk(6);

    // Reset in the middle of a transaction: the rest of it must be ignored
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(8'hEB, 4, r);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    base = wr_q.size();
    quiet_watch = 1'b1;
    spi_bits(8'hB0, 4, r);
    spi_bits(8'h6B, 8, r);
    spi_bits(8'h77, 8, r);
    check("ignored_xfer_active", 64'(xfer_active), 64'd0);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(6);
    quiet_watch = 1'b0;
    check("ignored_miso_quiet", 64'(miso_hi_cnt), 64'd0);
    check("ignored_no_strobe", 64'(wr_q.size() - base), 64'd0);
    check("ignored_pwr", 64'(pwr_mgmt), 64'h40);

    pulse_sample(64'h1234_ABCD_8001_7FFE);
    wait_clk(3);

    // Table of two-byte transactions
    for (int v = 0; v < 10; v++) begin
      base = wr_q.size();
      tx_buf[0] = vecs[v].cmd;
      tx_buf[1] = vecs[v].dat;
      run_xfer(2, -1, 64'd0);
      check($sformatf("vec%0d_cmd_miso", v), 64'(rx_buf[0]), 64'd0);
      check($sformatf("vec%0d_rx", v), 64'(rx_buf[1]), 64'(vecs[v].exp_rx));
      check($sformatf("vec%0d_wr_cnt", v), 64'(wr_q.size() - base), 64'(vecs[v].exp_wr));
      if (vecs[v].exp_wr == 1 && wr_q.size() > base)
        check($sformatf("vec%0d_wr", v), 64'(wr_q[base]), 64'({vecs[v].cmd[6:0], vecs[v].dat}));
      check($sformatf("vec%0d_pwr", v), 64'(pwr_mgmt), 64'(vecs[v].exp_pwr));
    end
    model_pwr = 8'h01;

    // Coherent burst from 0x3B
    tx_buf[0] = 8'hBB;
    for (int i = 1; i < 13; i++) tx_buf[i] = 8'h00;
    run_xfer(13, -1, 64'd0);
    for (int i = 0; i < 12; i++)
      check($sformatf("burst_b%0d", i), 64'(rx_buf[i+1]), 64'(exp_b[i]));

    // New sample mid-burst: this burst keeps old data, the next sees new data
    run_xfer(13, 4, 64'hCAFE_0102_0304_0506);
    for (int i = 0; i < 12; i++)
      check($sformatf("frozen_b%0d", i), 64'(rx_buf[i+1]), 64'(exp_b[i]));
    run_xfer(13, -1, 64'd0);
    for (int i = 0; i < 12; i++)
      check($sformatf("fresh_b%0d", i), 64'(rx_buf[i+1]), 64'(exp_c[i]));

    // Partial second byte of a write is discarded
    base = wr_q.size();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h6B, 8, r);
    spi_bits(8'h22, 5, r);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(6);
    check("partial_no_strobe", 64'(wr_q.size() - base), 64'd0);
    check("partial_pwr", 64'(pwr_mgmt), 64'h01);

    // Address wrap 0x7F -> 0x00, and a burst crossing WHO_AM_I
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_xfer(3, -1, 64'd0);
    check("wrap_7f", 64'(rx_buf[1]), 64'h00);
    check("wrap_00", 64'(rx_buf[2]), 64'h00);
    tx_buf[0] = 8'hF4; tx_buf[3] = 8'h00;
    run_xfer(4, -1, 64'd0);
    check("burst_74", 64'(rx_buf[1]), 64'h00);
    check("burst_75", 64'(rx_buf[2]), 64'h68);
    check("burst_76", 64'(rx_buf[3]), 64'h00);

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      n  = int'($urandom_range(1, 4));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = 7'h3A + 7'($urandom_range(0, 15));
      else a = picks[$urandom_range(0, 4)];
      tx_buf[0] = {rw, a};
      for (int i = 1; i < n; i++) tx_buf[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pulse_sample({$urandom, $urandom});
        wait_clk(2);
      end
      pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      base = wr_q.size();
      run_xfer(n, pa, {$urandom, $urandom});
      check("rnd_cmd_miso", 64'(rx_buf[0]), 64'd0);
      check("rnd_wr_cnt", 64'(wr_q.size() - base), rw ? 64'd0 : 64'(n - 1));
      cur = a;
      for (int i = 1; i < n; i++) begin
        if (rw) begin
          check($sformatf("rnd%0d_rd_%h", t, cur), 64'(rx_buf[i]), 64'(model_read(cur)));
        end else begin
          got = (base + i - 1 < wr_q.size()) ? wr_q[base + i - 1] : 15'h7FFF;
          check($sformatf("rnd%0d_wr", t), 64'(got), 64'({cur, tx_buf[i]}));
          if (cur == 7'h6B) model_pwr = tx_buf[i];
        end
        cur = cur + 7'd1;
      end
      check("rnd_pwr", 64'(pwr_mgmt), 64'(model_pwr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
